// File: rtl/ecall_io_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecall_io_sequencer_if
//  Description : Signal bundle between the core datapath and the ecall I/O
//                sequencer.
//                master : core side (drives ecall/register/IO inputs,
//                         consumes stall, regfile write port, tube and LEDs)
//                slave  : sequencer side
//  Signals     : ecall_req, a7_value[31:0], a0_value[31:0], switch_in[7:0],
//                confirm_btn -> sequencer
//                stall, io_we, io_waddr[4:0], io_wdata[31:0],
//                tube_data[31:0], tube_valid, wait_led, halted -> core/board
//  Revision    : 1.0 - initial release
// ============================================================================
interface ecall_io_sequencer_if;
    logic        ecall_req;
    logic [31:0] a7_value;
    logic [31:0] a0_value;
    logic [7:0]  switch_in;
    logic        confirm_btn;
    logic        stall;
    logic        io_we;
    logic [4:0]  io_waddr;
    logic [31:0] io_wdata;
    logic [31:0] tube_data;
    logic        tube_valid;
    logic        wait_led;
    logic        halted;

    modport master (
        output ecall_req, a7_value, a0_value, switch_in, confirm_btn,
        input  stall, io_we, io_waddr, io_wdata, tube_data, tube_valid,
               wait_led, halted
    );

    modport slave (
        input  ecall_req, a7_value, a0_value, switch_in, confirm_btn,
        output stall, io_we, io_waddr, io_wdata, tube_data, tube_valid,
               wait_led, halted
    );
endinterface
`default_nettype wire

// File: rtl/ecall_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ecall_io_sequencer
//  Description : Multi-cycle ecall service engine. Stalls the core while an
//                ecall is serviced, decodes the service from a7, prints a0
//                to the tube or reads the switch bank into a0, and uses a
//                debounced confirm button as the user handshake.
//  Ports       : clk   - core clock (rising edge)
//                reset - asynchronous, active-high
//                bus   - ecall_io_sequencer_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module ecall_io_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter logic [31:0] SVC_PRINT       = 32'd1,
    parameter logic [31:0] SVC_READ_U      = 32'd5,
    parameter logic [31:0] SVC_READ_S      = 32'd6,
    parameter logic [31:0] SVC_EXIT        = 32'd10
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ecall_io_sequencer_if.slave   bus
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [4:0]         c_A0_ADDR = 5'd10;

    localparam logic [2:0] c_S_IDLE         = 3'd0;
    localparam logic [2:0] c_S_DECODE       = 3'd1;
    localparam logic [2:0] c_S_WAIT_PRESS   = 3'd2;
    localparam logic [2:0] c_S_WAIT_RELEASE = 3'd3;
    localparam logic [2:0] c_S_COMMIT       = 3'd4;
    localparam logic [2:0] c_S_HALT         = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_db_level;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic [31:0]        r_svc;
    logic [31:0]        r_io_wdata;
    logic [31:0]        r_tube_data;
    logic               r_tube_valid;
    logic               w_db_change;
    logic               w_db_rise;
    logic               w_db_fall;
    logic               w_is_read;
    logic               w_stall;
    logic               w_io_we;
    logic               w_wait_led;
    logic               w_halted;

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1 <= bus.confirm_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_CNT_MAX) begin
                r_db_level <= ~r_db_level;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_CNT_ONE;
            end
        end
    end

    // Edge events fire in the cycle the debounced level is about to flip,
    // so a level that is already high when WAIT_PRESS is entered cannot
    // count as a press: it must fall and rise again first.
    assign w_db_change = (r_sync2 != r_db_level) && (r_db_cnt == c_CNT_MAX);
    assign w_db_rise   = w_db_change && !r_db_level;
    assign w_db_fall   = w_db_change &&  r_db_level;

    assign w_is_read = (r_svc == SVC_READ_U) || (r_svc == SVC_READ_S);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (bus.ecall_req) begin
                    w_next_state = c_S_DECODE;
                end
            end
            c_S_DECODE: begin
                if ((bus.a7_value == SVC_PRINT)  ||
                    (bus.a7_value == SVC_READ_U) ||
                    (bus.a7_value == SVC_READ_S)) begin
                    w_next_state = c_S_WAIT_PRESS;
                end else if (bus.a7_value == SVC_EXIT) begin
                    w_next_state = c_S_HALT;
                end else begin
                    w_next_state = c_S_COMMIT;
                end
            end
            c_S_WAIT_PRESS: begin
                if (w_db_rise) begin
                    w_next_state = c_S_WAIT_RELEASE;
                end
            end
            c_S_WAIT_RELEASE: begin
                if (w_db_fall) begin
                    w_next_state = c_S_COMMIT;
                end
            end
            c_S_COMMIT: w_next_state = c_S_IDLE;
            c_S_HALT:   w_next_state = c_S_HALT;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_stall    = 1'b0;
        w_io_we    = 1'b0;
        w_wait_led = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            // Combinational stall so the PC never advances past the ecall
            // in its first cycle.
            c_S_IDLE:         w_stall = bus.ecall_req;
            c_S_DECODE:       w_stall = 1'b1;
            c_S_WAIT_PRESS,
            c_S_WAIT_RELEASE: begin
                w_stall    = 1'b1;
                w_wait_led = 1'b1;
            end
            // Stall drops for exactly this cycle; ecall_req is ignored here.
            c_S_COMMIT:       w_io_we = w_is_read;
            c_S_HALT: begin
                w_stall  = 1'b1;
                w_halted = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: service code, read data, tube
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_svc        <= '0;
            r_io_wdata   <= '0;
            r_tube_data  <= '0;
            r_tube_valid <= 1'b0;
        end else begin
            if (r_state == c_S_DECODE) begin
                r_svc <= bus.a7_value;
                if (bus.a7_value == SVC_PRINT) begin
                    r_tube_data  <= bus.a0_value;
                    r_tube_valid <= 1'b1;
                end
            end
            // Switches are sampled on the accepted press, not at commit.
            if ((r_state == c_S_WAIT_PRESS) && w_db_rise) begin
                if (r_svc == SVC_READ_U) begin
                    r_io_wdata <= {24'd0, bus.switch_in};
                end else if (r_svc == SVC_READ_S) begin
                    r_io_wdata <= {{24{bus.switch_in[7]}}, bus.switch_in};
                end
            end
        end
    end

    assign bus.stall      = w_stall;
    assign bus.io_we      = w_io_we;
    assign bus.io_waddr   = c_A0_ADDR;
    assign bus.io_wdata   = r_io_wdata;
    assign bus.tube_data  = r_tube_data;
    assign bus.tube_valid = r_tube_valid;
    assign bus.wait_led   = w_wait_led;
    assign bus.halted     = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_ecall_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecall_io_sequencer
//  Description : Self-checking bench for ecall_io_sequencer with a short
//                debounce window. Cycle vectors are held for a given number
//                of cycles and outputs compared at the last cycle's negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecall_io_sequencer;

    localparam int c_DB = 4;

    typedef struct {
        logic        ecall;
        logic [31:0] a7;
        logic [31:0] a0;
        logic [7:0]  sw;
        logic        btn;
        int          cycles;
        logic        stall;
        logic        io_we;
        logic [31:0] wdata;
        logic [31:0] tube;
        logic        tv;
        logic        wl;
        logic        halted;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    ecall_io_sequencer_if u_if();

    ecall_io_sequencer #(
        .DEBOUNCE_CYCLES (c_DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ecall, input logic [31:0] a7,
                       input logic [31:0] a0, input logic [7:0] sw,
                       input logic btn, input int cycles,
                       input logic stall, input logic io_we,
                       input logic [31:0] wdata, input logic [31:0] tube,
                       input logic tv, input logic wl, input logic halted);
        vec_t v;
        v.ecall = ecall; v.a7 = a7; v.a0 = a0; v.sw = sw; v.btn = btn;
        v.cycles = cycles; v.stall = stall; v.io_we = io_we;
        v.wdata = wdata; v.tube = tube; v.tv = tv; v.wl = wl;
        v.halted = halted;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic stall,
                             input logic io_we, input logic [31:0] wdata,
                             input logic [31:0] tube, input logic tv,
                             input logic wl, input logic halted);
        check({tag, " stall"},      32'(u_if.stall),      32'(stall));
        check({tag, " io_we"},      32'(u_if.io_we),      32'(io_we));
        check({tag, " io_waddr"},   32'(u_if.io_waddr),   32'd10);
        check({tag, " io_wdata"},   u_if.io_wdata,        wdata);
        check({tag, " tube_data"},  u_if.tube_data,       tube);
        check({tag, " tube_valid"}, 32'(u_if.tube_valid), 32'(tv));
        check({tag, " wait_led"},   32'(u_if.wait_led),   32'(wl));
        check({tag, " halted"},     32'(u_if.halted),     32'(halted));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        u_if.ecall_req   = 1'b0;
        u_if.a7_value    = '0;
        u_if.a0_value    = '0;
        u_if.switch_in   = '0;
        u_if.confirm_btn = 1'b0;

        // ---------------- vector table ----------------
        // print 0x1234: press/release 10 cycles; commit lands 6 cycles
        // after the release edge (2 sync + 4 debounce)
        add(1, 1, 32'h1234, 8'h00, 0, 1,  1,0,32'h0,0,0,0,0);
        add(1, 1, 32'h1234, 8'h00, 0, 1,  1,0,32'h0,0,0,0,0);
        add(1, 1, 32'h1234, 8'h00, 0, 1,  1,0,32'h0,32'h1234,1,1,0);
        add(1, 1, 32'h1234, 8'h00, 1, 10, 1,0,32'h0,32'h1234,1,1,0);
        add(1, 1, 32'h1234, 8'h00, 0, 6,  1,0,32'h0,32'h1234,1,1,0);
        add(1, 1, 32'h1234, 8'h00, 0, 1,  0,0,32'h0,32'h1234,1,0,0);
        add(0, 0, 32'h0,    8'h00, 0, 1,  0,0,32'h0,32'h1234,1,0,0);
        // read signed 0xF0; switches change after the press
        add(1, 6, 32'h0, 8'hF0, 0, 1,  1,0,32'h0,32'h1234,1,0,0);
        add(1, 6, 32'h0, 8'hF0, 0, 1,  1,0,32'h0,32'h1234,1,0,0);
        add(1, 6, 32'h0, 8'hF0, 0, 1,  1,0,32'h0,32'h1234,1,1,0);
        add(1, 6, 32'h0, 8'hF0, 1, 10, 1,0,32'hFFFF_FFF0,32'h1234,1,1,0);
        add(1, 6, 32'h0, 8'h0F, 0, 6,  1,0,32'hFFFF_FFF0,32'h1234,1,1,0);
        add(1, 6, 32'h0, 8'h0F, 0, 1,  0,1,32'hFFFF_FFF0,32'h1234,1,0,0);
        add(0, 0, 32'h0, 8'h0F, 0, 1,  0,0,32'hFFFF_FFF0,32'h1234,1,0,0);
        // read unsigned 0xF0
        add(1, 5, 32'h0, 8'hF0, 0, 1,  1,0,32'hFFFF_FFF0,32'h1234,1,0,0);
        add(1, 5, 32'h0, 8'hF0, 0, 1,  1,0,32'hFFFF_FFF0,32'h1234,1,0,0);
        add(1, 5, 32'h0, 8'hF0, 0, 1,  1,0,32'hFFFF_FFF0,32'h1234,1,1,0);
        add(1, 5, 32'h0, 8'hF0, 1, 10, 1,0,32'h0000_00F0,32'h1234,1,1,0);
        add(1, 5, 32'h0, 8'h00, 0, 6,  1,0,32'h0000_00F0,32'h1234,1,1,0);
        add(1, 5, 32'h0, 8'h00, 0, 1,  0,1,32'h0000_00F0,32'h1234,1,0,0);
        add(0, 0, 32'h0, 8'h00, 0, 1,  0,0,32'h0000_00F0,32'h1234,1,0,0);
        // unknown service 99, then a back-to-back ecall
        add(1, 99, 32'h55, 8'h00, 0, 1, 1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 99, 32'h55, 8'h00, 0, 1, 1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 99, 32'h55, 8'h00, 0, 1, 0,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 99, 32'h55, 8'h00, 0, 1, 1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 99, 32'h55, 8'h00, 0, 1, 1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 99, 32'h55, 8'h00, 0, 1, 0,0,32'h0000_00F0,32'h1234,1,0,0);
        add(0, 0,  32'h0,  8'h00, 0, 1, 0,0,32'h0000_00F0,32'h1234,1,0,0);
        // read unsigned with 3-cycle glitches that must be rejected
        add(1, 5, 32'h0, 8'h5A, 0, 1,  1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 5, 32'h0, 8'h5A, 0, 1,  1,0,32'h0000_00F0,32'h1234,1,0,0);
        add(1, 5, 32'h0, 8'h5A, 0, 1,  1,0,32'h0000_00F0,32'h1234,1,1,0);
        for (int g = 0; g < 4; g++) begin
            add(1, 5, 32'h0, 8'h5A, 1, 3, 1,0,32'h0000_00F0,32'h1234,1,1,0);
            add(1, 5, 32'h0, 8'h5A, 0, 3, 1,0,32'h0000_00F0,32'h1234,1,1,0);
        end
        add(1, 5, 32'h0, 8'h5A, 1, 10, 1,0,32'h0000_005A,32'h1234,1,1,0);
        add(1, 5, 32'h0, 8'h5A, 0, 6,  1,0,32'h0000_005A,32'h1234,1,1,0);
        add(1, 5, 32'h0, 8'h5A, 0, 1,  0,1,32'h0000_005A,32'h1234,1,0,0);
        add(0, 0, 32'h0, 8'h5A, 0, 1,  0,0,32'h0000_005A,32'h1234,1,0,0);
        // exit: halted forever, button and further ecalls ignored
        add(1, 10, 32'h0, 8'h00, 0, 1,  1,0,32'h0000_005A,32'h1234,1,0,0);
        add(1, 10, 32'h0, 8'h00, 0, 1,  1,0,32'h0000_005A,32'h1234,1,0,0);
        add(0, 0,  32'h0, 8'h00, 0, 1,  1,0,32'h0000_005A,32'h1234,1,0,1);
        add(0, 0,  32'h0, 8'h00, 1, 10, 1,0,32'h0000_005A,32'h1234,1,0,1);
        add(0, 0,  32'h0, 8'h00, 0, 10, 1,0,32'h0000_005A,32'h1234,1,0,1);
        add(1, 1,  32'h77,8'h00, 0, 3,  1,0,32'h0000_005A,32'h1234,1,0,1);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0,0,32'h0,32'h0,0,0,0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            u_if.ecall_req   = vecs[i].ecall;
            u_if.a7_value    = vecs[i].a7;
            u_if.a0_value    = vecs[i].a0;
            u_if.switch_in   = vecs[i].sw;
            u_if.confirm_btn = vecs[i].btn;
            repeat (vecs[i].cycles - 1) @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].stall, vecs[i].io_we,
                      vecs[i].wdata, vecs[i].tube, vecs[i].tv, vecs[i].wl,
                      vecs[i].halted);
        end

        // ---------------- reset out of HALT ----------------
        u_if.ecall_req = 1'b0;
        #2 reset = 1'b1;
        #1 check_all("halt_reset", 0,0,32'h0,32'h0,0,0,0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- async reset mid-WAIT_PRESS ----------------
        @(posedge clk);
        #1;
        u_if.ecall_req = 1'b1;
        u_if.a7_value  = 32'd1;
        u_if.a0_value  = 32'hABCD;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all("wait_press", 1,0,32'h0,32'hABCD,1,1,0);
        #2 reset = 1'b1;
        #1 check("rst_async stall_with_req", 32'(u_if.stall), 32'd1);
        u_if.ecall_req = 1'b0;
        #1 check_all("rst_async", 0,0,32'h0,32'h0,0,0,0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all("post_reset_idle", 0,0,32'h0,32'h0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
